// File: rtl/conv2d_stream_layer.sv
// Streaming single-MAC 2D convolution: buffers one input frame, then computes
// each valid-window output pixel across all output channels and emits it as int8.
module conv2d_stream_layer #(
  parameter int IN_CH = 6,
  parameter int OUT_CH = 16,
  parameter int IN_W = 12,
  parameter int IN_H = 12,
  parameter int K = 5,
  parameter int ACC_W = 32,
  parameter logic signed [31:0] Q_MULT = 1,
  parameter int Q_SHIFT = 0,
  parameter bit RELU_EN = 1'b1,
  localparam int N_TAP = IN_CH*K*K,
  localparam int WAW = ($clog2(OUT_CH*N_TAP) > 0) ? $clog2(OUT_CH*N_TAP) : 1,
  localparam int BAW = ($clog2(OUT_CH) > 0) ? $clog2(OUT_CH) : 1
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_CH*8-1:0]    in_data,
  output logic [WAW-1:0]        w_addr,
  input  logic [7:0]            w_data,
  output logic [BAW-1:0]        b_addr,
  input  logic [31:0]           b_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_CH*8-1:0]   out_data,
  output logic                  out_last,
  output logic                  busy
);
  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_MAC = 2'd2, S_EMIT = 2'd3;
  localparam int PIX = IN_W*IN_H;
  localparam int OUT_W = IN_W-K+1;
  localparam int OUT_H = IN_H-K+1;
  localparam int AW = (PIX > 1) ? $clog2(PIX) : 1;
  localparam int CW = 16;
  localparam int ICW = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam logic signed [63:0] RND =
    (Q_SHIFT > 0) ? (64'sd1 <<< ((Q_SHIFT > 0) ? Q_SHIFT-1 : 0)) : 64'sd0;

  logic [1:0]              state;
  logic [IN_CH*8-1:0]      feat [PIX];
  logic [AW-1:0]           ld_addr, wr_addr, faddr;
  logic [CW-1:0]           px, py, kx, ky;
  logic [ICW-1:0]          ic;
  logic [BAW-1:0]          oc;
  logic [WAW-1:0]          w_ptr;
  // [0] tap issue, [1] product accumulate, [2] channel finalize
  logic [2:0]              vld_pipe;
  logic                    last1;
  logic signed [7:0]       feat1;
  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] acc, accb, r;
  logic signed [63:0]      r64, q64;
  logic [7:0]              sat8;
  logic [OUT_CH-1:0][7:0]  stage;
  logic [IN_CH*8-1:0]      frow;
  logic                    tap_last, pos_last;

  assign in_ready = !rst && (state == S_IDLE || state == S_LOAD);
  assign busy     = (state != S_IDLE);
  assign w_addr   = w_ptr;
  assign b_addr   = oc;

  assign tap_last = (kx == CW'(K-1)) && (ky == CW'(K-1)) && (ic == ICW'(IN_CH-1));
  assign pos_last = (px == CW'(OUT_W-1)) && (py == CW'(OUT_H-1));
  assign faddr    = (AW'(py) + AW'(ky)) * AW'(IN_W) + AW'(px) + AW'(kx);
  assign frow     = feat[faddr];
  assign wr_addr  = (state == S_IDLE) ? '0 : ld_addr;
  assign prod     = feat1 * $signed(w_data);

  // Bias add, optional ReLU, rounded requant and int8 saturation
  assign accb = acc + ACC_W'($signed(b_data));
  assign r    = (RELU_EN && accb < 0) ? '0 : accb;
  assign r64  = 64'(r);
  assign q64  = (r64 * 64'(Q_MULT) + RND) >>> Q_SHIFT;
  assign sat8 = (q64 > 64'sd127) ? 8'h7f : (q64 < -64'sd128) ? 8'h80 : q64[7:0];

  always_ff @(posedge clk)
    if (in_valid && in_ready) feat[wr_addr] <= in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ld_addr <= '0;
      px <= '0; py <= '0; kx <= '0; ky <= '0; ic <= '0; oc <= '0;
      w_ptr <= '0;
      vld_pipe <= '0;
      last1 <= 1'b0;
      feat1 <= '0;
      acc <= '0;
      stage <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      vld_pipe[2] <= vld_pipe[1] & last1;
      last1 <= vld_pipe[0] & tap_last;
      feat1 <= $signed(frow[ic*8 +: 8]);
      if (vld_pipe[1]) acc <= acc + ACC_W'(prod);
      case (state)
        S_IDLE: if (in_valid) begin
          ld_addr <= AW'(1);
          if (PIX == 1) begin
            state <= S_MAC;
            vld_pipe[0] <= 1'b1;
          end else state <= S_LOAD;
        end
        S_LOAD: if (in_valid) begin
          ld_addr <= ld_addr + AW'(1);
          if (ld_addr == AW'(PIX-1)) begin
            state <= S_MAC;
            vld_pipe[0] <= 1'b1;
          end
        end
        S_MAC: begin
          if (vld_pipe[0]) begin
            w_ptr <= w_ptr + WAW'(1);
            if (kx == CW'(K-1)) begin
              kx <= '0;
              if (ky == CW'(K-1)) begin
                ky <= '0;
                ic <= tap_last ? '0 : ic + ICW'(1);
              end else ky <= ky + CW'(1);
            end else kx <= kx + CW'(1);
            if (tap_last) vld_pipe[0] <= 1'b0;
          end
          if (vld_pipe[2]) begin
            stage[oc] <= sat8;
            acc <= '0;
            if (oc == BAW'(OUT_CH-1)) state <= S_EMIT;
            else begin
              oc <= oc + BAW'(1);
              vld_pipe[0] <= 1'b1;
            end
          end
        end
        default: begin
          if (!out_valid) begin
            out_data <= stage;
            out_valid <= 1'b1;
            out_last <= pos_last;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last <= 1'b0;
            oc <= '0;
            w_ptr <= '0;
            if (pos_last) begin
              px <= '0;
              py <= '0;
              state <= S_IDLE;
            end else begin
              if (px == CW'(OUT_W-1)) begin
                px <= '0;
                py <= py + CW'(1);
              end else px <= px + CW'(1);
              state <= S_MAC;
              vld_pipe[0] <= 1'b1;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_conv2d_stream_layer.sv
// Directed bench: two small-config instances (ReLU/no-shift and no-ReLU/shift-1)
// fed identical frames, compared against hand-computed lane values.
module tb_conv2d_stream_layer;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic [7:0] in_data;
  logic in_ready0, in_ready1, out_valid0, out_valid1, out_last0, out_last1, busy0, busy1;
  logic [4:0] w_addr0, w_addr1;
  logic [0:0] b_addr0, b_addr1;
  logic [7:0] w_data0, w_data1;
  logic [31:0] b_data0, b_data1;
  logic [15:0] out_data0, out_data1;

  logic signed [7:0] wrom [18];
  logic signed [31:0] brom [2];
  int e0 [4][2];
  int e1 [4][2];
  int n_chk = 0, n_pass = 0;

  localparam int R0 [4][2] = '{'{45, 0}, '{54, 1}, '{81, 4}, '{90, 5}};
  localparam int R1 [4][2] = '{'{23, 0}, '{27, 1}, '{41, 2}, '{45, 3}};

  always #5 clk = ~clk;

  conv2d_stream_layer #(.IN_CH(1), .OUT_CH(2), .IN_W(4), .IN_H(4), .K(3), .ACC_W(32),
    .Q_MULT(1), .Q_SHIFT(0), .RELU_EN(1'b1)) d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .w_addr(w_addr0), .w_data(w_data0), .b_addr(b_addr0), .b_data(b_data0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_last(out_last0), .busy(busy0));

  conv2d_stream_layer #(.IN_CH(1), .OUT_CH(2), .IN_W(4), .IN_H(4), .K(3), .ACC_W(32),
    .Q_MULT(1), .Q_SHIFT(1), .RELU_EN(1'b0)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .w_addr(w_addr1), .w_data(w_data1), .b_addr(b_addr1), .b_data(b_data1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_last(out_last1), .busy(busy1));

  always @(posedge clk) begin
    w_data0 <= wrom[w_addr0];
    w_data1 <= wrom[w_addr1];
    b_data0 <= brom[b_addr0];
    b_data1 <= brom[b_addr1];
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got %0d exp %0d", tag, got, exp);
  endtask

  task automatic set_rom(input int wv, input int bias0, input int bias1, input bit rast);
    for (int i = 0; i < 18; i++) wrom[i] = (!rast || i < 9) ? 8'(wv) : 8'sd0;
    if (rast) wrom[9] = 8'sd1;
    brom[0] = 32'(bias0);
    brom[1] = 32'(bias1);
  endtask

  task automatic set_uni(input int a0, input int a1, input int b0, input int b1);
    for (int p = 0; p < 4; p++) begin
      e0[p][0] = a0; e0[p][1] = a1; e1[p][0] = b0; e1[p][1] = b1;
    end
  endtask

  task automatic set_rast();
    for (int p = 0; p < 4; p++)
      for (int l = 0; l < 2; l++) begin
        e0[p][l] = R0[p][l];
        e1[p][l] = R1[p][l];
      end
  endtask

  // mode 0: every pixel = v; mode 1: pixel = raster index
  task automatic feed(input int mode, input int v, input bit gaps);
    int i = 0, cyc = 0;
    while (i < 16 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (gaps && $urandom_range(0, 2) == 0) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in_data = 8'((mode == 1) ? i : v);
      end
      if (in_valid && in_ready0) i++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("load_done", i, 16);
    chk("in_ready_mac", int'(in_ready0), 0);
  endtask

  task automatic collect(input bit stall);
    for (int p = 0; p < 4; p++) begin
      int cyc = 0;
      out_ready = !(stall && p == 1);
      while (!out_valid0 && cyc < 300) begin
        @(negedge clk);
        cyc++;
      end
      chk("out_valid", int'(out_valid0), 1);
      chk("d1_valid", int'(out_valid1), 1);
      if (!out_valid0) return;
      if (stall && p == 1) begin
        logic [15:0] snap;
        int stable;
        snap = out_data0;
        stable = 1;
        for (int s = 0; s < 20; s++) begin
          @(negedge clk);
          if (out_data0 !== snap || !out_valid0 || out_last0) stable = 0;
        end
        chk("stall_hold", stable, 1);
        out_ready = 1'b1;
      end
      chk($sformatf("d0_p%0d_l0", p), int'($signed(out_data0[7:0])), e0[p][0]);
      chk($sformatf("d0_p%0d_l1", p), int'($signed(out_data0[15:8])), e0[p][1]);
      chk($sformatf("d1_p%0d_l0", p), int'($signed(out_data1[7:0])), e1[p][0]);
      chk($sformatf("d1_p%0d_l1", p), int'($signed(out_data1[15:8])), e1[p][1]);
      chk($sformatf("last_p%0d", p), int'(out_last0), (p == 3) ? 1 : 0);
      @(posedge clk);
      @(negedge clk);
    end
    chk("busy_after", int'(busy0), 0);
    chk("in_ready_after", int'(in_ready0), 1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    set_rom(1, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready0), 0);
    chk("rst_out_valid", int'(out_valid0), 0);
    chk("rst_out_data", int'(out_data0), 0);
    chk("rst_busy", int'(busy0), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", int'(in_ready0), 1);

    set_rom(1, 0, 0, 1'b0);   set_uni(9, 9, 5, 5);           feed(0, 1, 1'b0);    collect(1'b0);
    set_rom(1, 0, -20, 1'b0); set_uni(9, 0, 5, -5);          feed(0, 1, 1'b0);    collect(1'b0);
    set_rom(1, 0, 0, 1'b0);   set_uni(0, 0, -4, -4);         feed(0, -1, 1'b0);   collect(1'b0);
    set_rom(127, 0, 0, 1'b0); set_uni(127, 127, 127, 127);   feed(0, 127, 1'b0);  collect(1'b0);
    set_rom(127, 0, 0, 1'b0); set_uni(0, 0, -128, -128);     feed(0, -128, 1'b0); collect(1'b0);
    set_rom(1, 0, 0, 1'b1);   set_rast();                    feed(1, 0, 1'b0);    collect(1'b0);
    feed(1, 0, 1'b1);
    collect(1'b1);

    // abandon a frame mid-computation, then run a fresh one
    feed(0, 100, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid0), 0);
    chk("midrst_busy0", int'(busy0), 0);
    chk("midrst_busy1", int'(busy1), 0);
    rst = 1'b0;
    feed(1, 0, 1'b0);
    collect(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
